mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the data width of every data port.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] high means requester i has a word pending on in_i.
REQ-005 The block SHALL have ports in0, in1, in2, in3, input, WIDTH bits each: requester data, held stable while req[i] is high.
REQ-006 The block SHALL have port ack, output, 4 bits: one-hot or zero; ack[i] high means in_i is captured at this clock edge.
REQ-007 The block SHALL have port out, output reg, WIDTH bits: the registered winning word.
REQ-008 The block SHALL have port sel, output reg, 2 bits: the source index of the word currently on out.
REQ-009 The block SHALL have port out_valid, output reg, 1 bit: out holds an undelivered word.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out at this edge when out_valid is high.

Function
REQ-011 The block SHALL implement state IDLE (out_valid=0) and state FULL (out_valid=1), with out_valid decoded from state.
REQ-012 The block SHALL define load as (state==IDLE || out_ready) && |req.
REQ-013 The block SHALL, on a load, capture the winner: out<=in_w, sel<=w, state<=FULL, and hold ack[w]=1 combinationally in that same cycle.
REQ-014 The block SHALL make a transfer from FULL with out_ready=1 and req=0 go to IDLE, leaving out and sel unchanged.
REQ-015 The block SHALL hold out, sel and state while in FULL with out_ready=0; ack SHALL be 0 in that cycle, whatever req is.
REQ-016 The block SHALL keep ack at 0 in IDLE when req=0.
REQ-017 The block SHALL select the winner round-robin from a 2-bit pointer ptr, searching indices ptr+1, ptr+2, ptr+3, ptr (mod 4) and taking the first with req high.
REQ-018 The block SHALL update ptr to w on every load and only on a load.
REQ-019 The block SHALL give latency from req[i] rising (in IDLE, i winning) to out_valid of exactly 1 clock.
REQ-020 The block SHALL sustain throughput of one word per clock while out_ready=1 and |req=1.
REQ-021 The block SHALL, with all four requesters continuously requesting, produce the grant order rotating 0,1,2,3,0,... with no requester waiting more than 3 loads.
REQ-022 The block SHALL accept simultaneous out_ready and new req in FULL, so that a transfer and a load occur at the same edge with no bubble.

Reset
REQ-023 The block SHALL, when reset=1 at a rising edge, set state<=IDLE, out<=0, sel<=0 and ptr<=3, so that index 0 has first priority.
REQ-024 The block SHALL force ack to 0 during any cycle with reset=1, so that no capture is reported.
REQ-025 The block SHALL make reset dominate load and transfer at the same edge, with any word in out discarded.

Configuration
REQ-026 The block SHALL, when macro MUX4_RR_ARBITER_LOCK_EN is defined, add input port lock, 4 bits; if req[ptr] && lock[ptr] at a load, winner w=ptr regardless of rotation, and ptr is unchanged.
REQ-027 The block SHALL, when MUX4_RR_ARBITER_LOCK_EN is undefined, have no lock port and use pure round-robin per REQ-017.

Verification
REQ-028 The bench SHALL cover reset then idle: reset=1 for 2 clocks, req=0 -> out=0, sel=0, out_valid=0, ack=0.
REQ-029 The bench SHALL cover single request: req=4'b0100, in2=8'hA5, out_ready=1 -> ack=4'b0100 for 1 cycle; next clock out=8'hA5, sel=2, out_valid=1.
REQ-030 The bench SHALL cover full contention: req=4'b1111, out_ready=1 held for 8 clocks -> sel sequence 0,1,2,3,0,1,2,3 and one ack bit per clock.
REQ-031 The bench SHALL cover backpressure: FULL with out=8'h11, out_ready=0 for 3 clocks, req=4'b0010 -> out holds 8'h11 and ack=0; when out_ready=1 -> ack=4'b0010 and in1 appears next clock.
REQ-032 The bench SHALL cover reset mid-stream: reset=1 while out_valid=1 and req=4'b1000 -> next clock out_valid=0, out=0; first load after release grants the lowest active index from 0.
REQ-033 The bench SHALL cover lock, with LOCK_EN defined: req=4'b0011, lock=4'b0001, first grant 0 -> sel stays 0 for every load until lock[0]=0, then the next load grants 1.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - 4-input round-robin arbiter feeding a one-word output register
// Optional MUX4_RR_ARBITER_LOCK_EN adds a lock input that pins the grant to the last winner.
module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
`ifdef MUX4_RR_ARBITER_LOCK_EN
  input  logic [3:0]       lock,
`endif
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       sel,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       win;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] win_data;

  // Search order starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[ptr_q + 2'(k)]) begin
        found = 1'b1;
        win   = ptr_q + 2'(k);
      end
    end
`ifdef MUX4_RR_ARBITER_LOCK_EN
    if (req[ptr_q] && lock[ptr_q]) begin
      win = ptr_q;
    end
`endif
  end

  always_comb begin
    case (win)
      2'd0:    win_data = in0;
      2'd1:    win_data = in1;
      2'd2:    win_data = in2;
      default: win_data = in3;
    endcase
  end

  assign load = ((state_q == IDLE) || out_ready) && (|req);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      state_d = FULL;
      out_d   = win_data;
      sel_d   = win;
      ptr_d   = win;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ack       = (load && !reset) ? (4'd1 << win) : 4'd0;
  assign out       = out_q;
  assign sel       = sel_q;
  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard bench for mux4_rr_arbiter with a queue-based reference model
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'd0;
  logic [3:0] lock = 4'd0;
  logic [7:0] din [4];
  logic [3:0] ack;
  logic [7:0] out;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_ready = 1'b0;

  logic [7:0] nxt_din [4];
  logic [3:0] nxt_lock = 4'd0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] ack;
    logic       valid;
  } cyc_t;

  cyc_t       cq [$];
  logic [9:0] wq [$];

  bit         m_full = 1'b0;
  int         m_last = 3;
  logic [3:0] m_ack = 4'd0;

  mux4_rr_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
`ifdef MUX4_RR_ARBITER_LOCK_EN
    .lock      (lock),
`endif
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .in3       (din[3]),
    .ack       (ack),
    .out       (out),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input logic [3:0] lk, input int last);
    if (r[last] && lk[last]) return last;
    for (int d = 1; d <= 4; d++) begin
      if (r[(last + d) % 4]) return (last + d) % 4;
    end
    return -1;
  endfunction

  task automatic step();
    cyc_t       c;
    int         w;
    logic [3:0] lk;
    bit         ld;
`ifdef MUX4_RR_ARBITER_LOCK_EN
    lk = lock;
`else
    lk = 4'd0;
`endif
    c.valid = m_full;
    c.ack   = 4'd0;
    ld = !reset && (!m_full || out_ready) && (req != 4'd0);
    if (reset) begin
      m_full = 1'b0;
      m_last = 3;
      wq.delete();
    end else if (ld) begin
      w = pick(req, lk, m_last);
      c.ack = 4'(1 << w);
      wq.push_back({2'(w), din[w]});
      m_last = w;
      m_full = 1'b1;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
    cq.push_back(c);
    m_ack = c.ack;
  endtask

  task automatic drive(input logic rst, input logic [3:0] r, input logic rdy);
    @(posedge clk);
    #1;
    reset     = rst;
    req       = r;
    out_ready = rdy;
    lock      = nxt_lock;
    for (int i = 0; i < 4; i++) din[i] = nxt_din[i];
    step();
  endtask

  cyc_t       mon_c;
  logic [9:0] mon_w;

  always @(negedge clk) begin
    if (cq.size() > 0) begin
      mon_c = cq.pop_front();
      chk("ack", int'(ack), int'(mon_c.ack));
      chk("out_valid", int'(out_valid), int'(mon_c.valid));
      if (out_valid && out_ready && !reset) begin
        if (wq.size() == 0) begin
          chk("word_expected", 0, 1);
        end else begin
          mon_w = wq.pop_front();
          chk("out", int'(out), int'(mon_w[7:0]));
          chk("sel", int'(sel), int'(mon_w[9:8]));
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       rdy;
    logic       rst;
    for (int i = 0; i < 4; i++) begin
      din[i]     = 8'd0;
      nxt_din[i] = 8'd0;
    end

    // reset then idle
    drive(1'b1, 4'd0, 1'b0);
    drive(1'b1, 4'd0, 1'b0);
    drive(1'b0, 4'd0, 1'b0);
    @(negedge clk);
    chk("reset_out", int'(out), 0);
    chk("reset_sel", int'(sel), 0);

    // single request
    nxt_din[2] = 8'hA5;
    drive(1'b0, 4'b0100, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);

    // full contention from a fresh pointer
    drive(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) nxt_din[i] = 8'h40 + 8'(i);
    for (int i = 0; i < 8; i++) drive(1'b0, 4'b1111, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);

    // backpressure
    nxt_din[0] = 8'h11;
    nxt_din[1] = 8'h22;
    drive(1'b0, 4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b0010, 1'b0);
    @(negedge clk);
    chk("bp_hold_out", int'(out), 8'h11);
    drive(1'b0, 4'b0010, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);

    // reset mid-stream
    nxt_din[3] = 8'h33;
    drive(1'b0, 4'b1000, 1'b0);
    drive(1'b1, 4'b1000, 1'b0);
    drive(1'b0, 4'b0000, 1'b0);
    @(negedge clk);
    chk("midrst_out", int'(out), 0);
    nxt_din[1] = 8'h5A;
    drive(1'b0, 4'b1010, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);

`ifdef MUX4_RR_ARBITER_LOCK_EN
    drive(1'b1, 4'd0, 1'b0);
    nxt_din[0] = 8'hC0;
    nxt_din[1] = 8'hC1;
    nxt_lock   = 4'b0001;
    for (int i = 0; i < 4; i++) drive(1'b0, 4'b0011, 1'b1);
    nxt_lock = 4'b0000;
    drive(1'b0, 4'b0011, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
`endif

    // randomized traffic: each requester holds its word until acked
    r = 4'd0;
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_ack[i] || !r[i]) begin
          r[i] = m_ack[i] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
          nxt_din[i] = 8'($urandom);
        end
      end
`ifdef MUX4_RR_ARBITER_LOCK_EN
      nxt_lock = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
`endif
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      drive(rst, r, rdy);
      if (rst) r = 4'd0;
    end

    nxt_lock = 4'd0;
    for (int i = 0; i < 3; i++) drive(1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    #1;
    chk("drain_empty", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
